// File: rtl/wdg_rst_gen.sv
// wdg_rst_gen: reset generator sitting behind the APB4 watchdog.
// Merges the watchdog request, an external reset pin and a software pulse
// into one stretched, synchronously released system reset, and records the
// cause of every reset in a sticky register.
// Optional build macro: WDG_RST_GEN_GLITCH_FLT_EN adds a 4-cycle glitch
// filter on the synchronized external reset pin.
module wdg_rst_gen #(
   parameter int STRETCH_WIDTH = 8,
   parameter int POR_STRETCH   = 16,
   parameter int SYNC_STAGE    = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     wdg_rst_i,
   input  logic                     ext_rst_n_i,
   input  logic                     sw_rst_i,
   input  logic [STRETCH_WIDTH-1:0] stretch_i,
   input  logic                     cause_clr_i,
   output logic                     sys_rst_n_o,
   output logic [3:0]               rst_cause_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                   state;
   logic [STRETCH_WIDTH-1:0] cnt;

   logic [SYNC_STAGE-1:0]    wdg_sync;
   logic [SYNC_STAGE-1:0]    ext_sync;
   logic                     wdg_prev;

   logic                     wdg_s;
   logic                     ext_low;
   logic                     ext_req;
   logic                     wdg_ev;
   logic                     sw_ev;
   logic                     restart;
   logic                     hold_cond;

   // Hold-low length to load into the down-counter; a zero length still
   // produces one low cycle, so the counter start value is max(len,1)-1.
   function automatic logic [STRETCH_WIDTH-1:0] load_len(
      input logic [STRETCH_WIDTH-1:0] len
   );
      return (len == '0) ? '0 : (len - STRETCH_WIDTH'(1));
   endfunction

   // Synchronizers; both reset to the inactive level of their input.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wdg_sync <= '0;
         ext_sync <= '1;
      end else begin
         wdg_sync <= {wdg_sync[SYNC_STAGE-2:0], wdg_rst_i};
         ext_sync <= {ext_sync[SYNC_STAGE-2:0], ext_rst_n_i};
      end
   end

   assign wdg_s   = wdg_sync[SYNC_STAGE-1];
   assign ext_low = ~ext_sync[SYNC_STAGE-1];

   // Previous synced watchdog level for rising-edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wdg_prev <= 1'b0;
      end else begin
         wdg_prev <= wdg_s;
      end
   end

   assign wdg_ev = wdg_s & ~wdg_prev;
   assign sw_ev  = sw_rst_i;

`ifdef WDG_RST_GEN_GLITCH_FLT_EN
   logic [1:0] flt_cnt;

   // Saturating count of consecutive low cycles on the synced pin; any high
   // cycle clears it, so release of the request is immediate.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         flt_cnt <= 2'd0;
      end else if (!ext_low) begin
         flt_cnt <= 2'd0;
      end else if (flt_cnt != 2'd3) begin
         flt_cnt <= flt_cnt + 2'd1;
      end
   end

   // Request only on the 4th (and later) consecutive low cycle.
   assign ext_req = ext_low & (flt_cnt == 2'd3);
`else
   assign ext_req = ext_low;
`endif

   // Edge events restart the hold; level sources keep the reset in HOLD.
   assign restart   = wdg_ev | sw_ev;
   assign hold_cond = ext_req | wdg_s;

   // Sequencer with registered reset and busy outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_ASSERT;
         cnt         <= STRETCH_WIDTH'(POR_STRETCH - 1);
         sys_rst_n_o <= 1'b0;
         busy_o      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (restart || ext_req) begin
                  state       <= ST_ASSERT;
                  cnt         <= load_len(stretch_i);
                  sys_rst_n_o <= 1'b0;
                  busy_o      <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (restart) begin
                  cnt <= load_len(stretch_i);
               end else if (cnt == '0) begin
                  if (hold_cond) begin
                     state <= ST_HOLD;
                  end else begin
                     state       <= ST_IDLE;
                     sys_rst_n_o <= 1'b1;
                     busy_o      <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - STRETCH_WIDTH'(1);
               end
            end
            ST_HOLD: begin
               if (restart) begin
                  state <= ST_ASSERT;
                  cnt   <= load_len(stretch_i);
               end else if (!hold_cond) begin
                  state       <= ST_IDLE;
                  sys_rst_n_o <= 1'b1;
                  busy_o      <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               sys_rst_n_o <= 1'b1;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

   // Sticky cause bits: clear drops all four, a same-cycle set wins, and the
   // POR bit is set only by the power-on reset itself.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rst_cause_o <= 4'b0001;
      end else begin
         rst_cause_o <= (cause_clr_i ? 4'b0000 : rst_cause_o)
                        | {sw_ev, wdg_ev, ext_req, 1'b0};
      end
   end

endmodule
